// File: rtl/frame_tx_serializer_if.sv
// frame_tx_serializer_if
//   Bundles the frame request, payload handshake and serial line outputs of
//   frame_tx_serializer.
//   master : frame source side (drives start/len/s_data/s_valid)
//   slave  : serializer side (drives s_ready and the tx/status outputs)
//   Signals:
//     start   - one-cycle frame request
//     len     - payload byte count, sampled with start
//     s_data  - payload byte
//     s_valid - s_data valid
//     s_ready - payload byte taken this cycle when s_valid=1
//     tx_bit  - serial NRZ output, MSB first, idles at 0
//     tx_en   - high for the whole frame
//     busy    - frame in progress
//     done    - one-cycle pulse on normal completion
//     abort   - one-cycle pulse on abnormal termination
interface frame_tx_serializer_if;
  logic       start;
  logic [7:0] len;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       tx_bit;
  logic       tx_en;
  logic       busy;
  logic       done;
  logic       abort;

  modport master (
    output start, len, s_data, s_valid,
    input  s_ready, tx_bit, tx_en, busy, done, abort
  );

  modport slave (
    input  start, len, s_data, s_valid,
    output s_ready, tx_bit, tx_en, busy, done, abort
  );
endinterface

// File: rtl/frame_tx_serializer.sv
// frame_tx_serializer
//   Serializes a frame (preamble, sync byte, length byte, payload and an
//   optional CRC-8) as an NRZ bit stream, MSB first, each bit held for SPB
//   sample clocks. Frames start and continue only while the PLL is locked.
//   Optional feature macro: FRAME_TX_CRC8_EN appends a CRC-8 (poly 0x07,
//   init 0x00, no reflection, no final XOR) over the len and payload bytes.
//   Ports:
//     refclk - sample clock, all logic on its rising edge
//     rst    - asynchronous active-high reset
//     locked - PLL lock indication
//     bus    - frame_tx_serializer_if.slave (request, payload, tx outputs)
module frame_tx_serializer #(
  parameter int         SPB            = 40,
  parameter int         PREAMBLE_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hD3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  frame_tx_serializer_if.slave  bus
);

  localparam int SCW = (SPB > 1) ? $clog2(SPB) : 1;
  // Byte counter holds the preamble index, then the remaining payload count.
  localparam int BCW = ($clog2(PREAMBLE_BYTES) > 8) ? $clog2(PREAMBLE_BYTES) : 8;
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(SPB - 1);
  localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]     PRE_BYTE  = 8'hAA;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SYNC = 3'd2;
  localparam logic [2:0] ST_LEN  = 3'd3;
  localparam logic [2:0] ST_PAY  = 3'd4;
`ifdef FRAME_TX_CRC8_EN
  localparam logic [2:0] ST_CRC  = 3'd5;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [7:0] crc_r;
`endif

  logic [2:0]     state_r;
  logic [SCW-1:0] samp_cnt_r;
  logic [2:0]     bit_cnt_r;
  logic [BCW-1:0] byte_cnt_r;
  logic [7:0]     shift_r;
  logic [7:0]     len_r;
  logic           busy_r;
  logic           done_r;
  logic           abort_r;

  logic           boundary_s;
  logic           need_pay_s;
  logic           underrun_s;
  logic           s_ready_s;

  // Byte boundary detection and payload request decode.
  always_comb begin
    boundary_s = 1'b0;
    need_pay_s = 1'b0;
    if (busy_r && (samp_cnt_r == SAMP_LAST) && (bit_cnt_r == 3'd7)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
    case (state_r)
      ST_LEN:  need_pay_s = 1'b1;
      ST_PAY:  need_pay_s = (byte_cnt_r != {BCW{1'b0}});
      default: need_pay_s = 1'b0;
    endcase
    // Lock loss takes priority, so no byte is offered in the abort cycle.
    s_ready_s  = boundary_s & need_pay_s & locked;
    underrun_s = boundary_s & need_pay_s & ~bus.s_valid;
  end

  // Frame sequencing, bit timing and shift register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      samp_cnt_r <= {SCW{1'b0}};
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= {BCW{1'b0}};
      shift_r    <= 8'h00;
      len_r      <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      abort_r    <= 1'b0;
`ifdef FRAME_TX_CRC8_EN
      crc_r      <= 8'h00;
`endif
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      if (!busy_r) begin
        if (bus.start && locked && (bus.len != 8'd0)) begin
          state_r    <= ST_PRE;
          samp_cnt_r <= {SCW{1'b0}};
          bit_cnt_r  <= 3'd0;
          byte_cnt_r <= {BCW{1'b0}};
          shift_r    <= PRE_BYTE;
          len_r      <= bus.len;
          busy_r     <= 1'b1;
`ifdef FRAME_TX_CRC8_EN
          crc_r      <= 8'h00;
`endif
        end
      end else if (!locked || underrun_s) begin
        abort_r    <= 1'b1;
        state_r    <= ST_IDLE;
        busy_r     <= 1'b0;
        shift_r    <= 8'h00;
        samp_cnt_r <= {SCW{1'b0}};
        bit_cnt_r  <= 3'd0;
      end else if (boundary_s) begin
        samp_cnt_r <= {SCW{1'b0}};
        bit_cnt_r  <= 3'd0;
        case (state_r)
          ST_PRE: begin
            if (byte_cnt_r == PRE_LAST) begin
              shift_r <= SYNC_BYTE;
              state_r <= ST_SYNC;
            end else begin
              shift_r    <= PRE_BYTE;
              byte_cnt_r <= byte_cnt_r + BCW'(1);
            end
          end
          ST_SYNC: begin
            shift_r <= len_r;
            state_r <= ST_LEN;
`ifdef FRAME_TX_CRC8_EN
            crc_r   <= crc8_step(crc_r, len_r);
`endif
          end
          ST_LEN: begin
            // byte_cnt counts payload bytes still to be requested after this one.
            shift_r    <= bus.s_data;
            byte_cnt_r <= BCW'(len_r) - BCW'(1);
            state_r    <= ST_PAY;
`ifdef FRAME_TX_CRC8_EN
            crc_r      <= crc8_step(crc_r, bus.s_data);
`endif
          end
          ST_PAY: begin
            if (byte_cnt_r != {BCW{1'b0}}) begin
              shift_r    <= bus.s_data;
              byte_cnt_r <= byte_cnt_r - BCW'(1);
`ifdef FRAME_TX_CRC8_EN
              crc_r      <= crc8_step(crc_r, bus.s_data);
`endif
            end else begin
`ifdef FRAME_TX_CRC8_EN
              shift_r <= crc_r;
              state_r <= ST_CRC;
`else
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              shift_r <= 8'h00;
`endif
            end
          end
`ifdef FRAME_TX_CRC8_EN
          ST_CRC: begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            shift_r <= 8'h00;
          end
`endif
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            shift_r <= 8'h00;
          end
        endcase
      end else if (samp_cnt_r == SAMP_LAST) begin
        samp_cnt_r <= {SCW{1'b0}};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        shift_r    <= {shift_r[6:0], 1'b0};
      end else begin
        samp_cnt_r <= samp_cnt_r + SCW'(1);
      end
    end
  end

  // shift_r is cleared whenever idle, so its MSB is already the idle level.
  assign bus.tx_bit  = shift_r[7];
  assign bus.tx_en   = busy_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.abort   = abort_r;
  assign bus.s_ready = s_ready_s;

endmodule

// File: tb/tb_frame_tx_serializer.sv
module tb_frame_tx_serializer;
  localparam int SPB  = 4;
  localparam int PRE  = 4;
  localparam int BITC = SPB * 8;

  logic refclk = 1'b0;
  logic rst;
  logic locked;

  frame_tx_serializer_if bus();

  frame_tx_serializer #(.SPB(SPB), .PREAMBLE_BYTES(PRE), .SYNC_BYTE(8'hD3)) dut (
    .refclk (refclk),
    .rst    (rst),
    .locked (locked),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] pay_q[$];
  logic [7:0] mdl_q[$];
  logic [7:0] exp_bytes[$];
  int exp_kind[$];    // 0 = done, 1 = abort, 2 = cut by reset
  int exp_cycles[$];
  int exp_ready[$];
  int exp_nb[$];
  int exp_done_total  = 0;
  int exp_abort_total = 0;
  int done_seen  = 0;
  int abort_seen = 0;

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // CRC-8 by long division of the zero-augmented message by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input logic [7:0] msg[$]);
    logic [8:0] rem;
    logic [7:0] cur;
    rem = 9'h000;
    for (int i = 0; i <= msg.size(); i++) begin
      cur = (i < msg.size()) ? msg[i] : 8'h00;
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], cur[b]};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  task automatic build_frame(input int l, input logic [7:0] frm[$]);
    logic [7:0] cm[$];
    mdl_q.delete();
    for (int i = 0; i < PRE; i++) mdl_q.push_back(8'hAA);
    mdl_q.push_back(8'hD3);
    mdl_q.push_back(8'(l));
    cm.push_back(8'(l));
    foreach (frm[i]) begin
      mdl_q.push_back(frm[i]);
      cm.push_back(frm[i]);
    end
`ifdef FRAME_TX_CRC8_EN
    mdl_q.push_back(crc_model(cm));
`endif
  endtask

  task automatic push_rec(input int kind, input int cycles, input int ready, input int nb);
    exp_kind.push_back(kind);
    exp_cycles.push_back(cycles);
    exp_ready.push_back(ready);
    exp_nb.push_back(nb);
    for (int i = 0; i < nb; i++) exp_bytes.push_back(mdl_q[i]);
    if (kind == 0) exp_done_total++;
    if (kind == 1) exp_abort_total++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.tx_en) && n < 5000) begin
      tick(1);
      n++;
    end
    if (n >= 5000) check("idle_timeout", 1, 0);
  endtask

  task automatic do_start(input int l, input bit b2b);
    int n = 0;
    if (b2b) begin
      while (!bus.done && n < 5000) begin
        @(negedge refclk);
        n++;
      end
      if (!bus.done) check("b2b_done_timeout", 1, 0);
    end
    bus.start = 1'b1;
    bus.len   = 8'(l);
    @(posedge refclk);
    #1;
    bus.start = 1'b0;
    if (b2b) check("b2b_tx_en_rise", int'(bus.tx_en), 1);
  endtask

  task automatic send_frame(input logic [7:0] frm[$], input bit b2b);
    build_frame(frm.size(), frm);
    push_rec(0, BITC * mdl_q.size(), frm.size(), mdl_q.size());
    foreach (frm[i]) pay_q.push_back(frm[i]);
    do_start(frm.size(), b2b);
  endtask

  task automatic check_quiet(input int n, input string name);
    int act = 0;
    repeat (n) begin
      tick(1);
      if (bus.busy || bus.tx_en || bus.done || bus.abort) act++;
    end
    check(name, act, 0);
  endtask

  // Payload source: presents the head of pay_q and pops it once taken.
  initial begin : feeder
    bit take;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    forever begin
      @(negedge refclk);
      take = bus.s_ready && bus.s_valid;
      @(posedge refclk);
      #1;
      if (take && pay_q.size() > 0) void'(pay_q.pop_front());
      if (pay_q.size() > 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = pay_q[0];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
      end
    end
  end

  // Monitor: captures each tx_en window and scores it against the queue.
  initial begin : monitor
    bit in_frame;
    bit prev_rdy;
    bit cap[$];
    int rdy, consec, k, ec, er, nb, mism, v, base;
    logic [7:0] eb;
    in_frame = 1'b0;
    prev_rdy = 1'b0;
    rdy = 0;
    consec = 0;
    forever begin
      @(negedge refclk);
      if (bus.done === 1'b1) done_seen++;
      if (bus.abort === 1'b1) abort_seen++;
      if (bus.tx_en === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cap.delete();
          rdy = 0;
          consec = 0;
          prev_rdy = 1'b0;
        end
        cap.push_back(bus.tx_bit);
        if (bus.s_ready) begin
          rdy++;
          if (prev_rdy) consec++;
        end
        prev_rdy = bus.s_ready;
      end else if (in_frame) begin
        in_frame = 1'b0;
        if (exp_kind.size() == 0) begin
          check("unexpected_frame", cap.size(), 0);
        end else begin
          k  = exp_kind.pop_front();
          ec = exp_cycles.pop_front();
          er = exp_ready.pop_front();
          nb = exp_nb.pop_front();
          check("frame_cycles", cap.size(), ec);
          check("end_pulse", int'(bus.done) + 2 * int'(bus.abort), (k == 0) ? 1 : ((k == 1) ? 2 : 0));
          check("s_ready_cycles", rdy, er);
          check("s_ready_consecutive", consec, 0);
          check("idle_after_end", int'(bus.tx_bit) + 2 * int'(bus.busy), 0);
          mism = 0;
          for (int b = 0; b < nb; b++) begin
            eb = exp_bytes.pop_front();
            base = b * BITC;
            if (base + BITC <= cap.size()) begin
              v = 0;
              for (int t = 0; t < 8; t++) begin
                v = (v << 1) | int'(cap[base + t * SPB]);
                for (int s = 1; s < SPB; s++)
                  if (cap[base + t * SPB + s] != cap[base + t * SPB]) mism++;
              end
              check($sformatf("frame_byte%0d", b), v, int'(eb));
            end else begin
              check($sformatf("frame_byte%0d_missing", b), cap.size(), base + BITC);
            end
          end
          check("bit_hold", mism, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] frm[$];
    int l;
    bit b2b;
    rst = 1'b1;
    locked = 1'b1;
    bus.start = 1'b0;
    bus.len = 8'h00;
    tick(3);
    check("rst_tx_bit", int'(bus.tx_bit), 0);
    check("rst_tx_en", int'(bus.tx_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_abort", int'(bus.abort), 0);
    check("rst_s_ready", int'(bus.s_ready), 0);
    rst = 1'b0;
    tick(2);

    // Directed single-byte frame.
    frm.delete();
`ifdef FRAME_TX_CRC8_EN
    frm.push_back(8'h00);
`else
    frm.push_back(8'h5A);
`endif
    send_frame(frm, 1'b0);
    wait_idle();

    // len=0 start is ignored.
    do_start(0, 1'b0);
    check_quiet(40, "len0_ignored");

    // Underrun: only the first of three payload bytes is supplied.
    frm.delete();
    for (int j = 0; j < 3; j++) frm.push_back(8'($urandom_range(0, 255)));
    build_frame(3, frm);
    push_rec(1, BITC * (PRE + 3), 2, PRE + 3);
    pay_q.push_back(frm[0]);
    do_start(3, 1'b0);
    wait_idle();
    tick(2);
    pay_q.delete();

    // Lock loss part way into the sync byte.
    frm.delete();
    for (int j = 0; j < 2; j++) frm.push_back(8'($urandom_range(0, 255)));
    build_frame(2, frm);
    push_rec(1, PRE * BITC + 11, 0, PRE);
    foreach (frm[j]) pay_q.push_back(frm[j]);
    do_start(2, 1'b0);
    tick(PRE * BITC + 10);
    locked = 1'b0;
    tick(1);
    check("lock_abort_pulse", int'(bus.abort), 1);
    check("lock_tx_en_low", int'(bus.tx_en), 0);
    pay_q.delete();
    do_start(3, 1'b0);
    check_quiet(40, "unlocked_start_ignored");
    locked = 1'b1;
    tick(2);

    // Reset asserted mid-preamble clears outputs without a clock edge.
    frm.delete();
    frm.push_back(8'h3C);
    build_frame(1, frm);
    push_rec(2, 50, 0, 1);
    pay_q.push_back(8'h3C);
    do_start(1, 1'b0);
    tick(50);
    rst = 1'b1;
    #1;
    check("rst_async_clear", int'(bus.tx_en) + 2 * int'(bus.busy) + 4 * int'(bus.tx_bit), 0);
    tick(2);
    rst = 1'b0;
    pay_q.delete();
    tick(2);

    // Directed back-to-back pair.
    frm.delete();
    frm.push_back(8'hC3);
    frm.push_back(8'h81);
    send_frame(frm, 1'b0);
    frm.delete();
    frm.push_back(8'h7E);
    send_frame(frm, 1'b1);

    // Randomized frames with ignored starts and back-to-back issue.
    for (int i = 0; i < 12; i++) begin
      l = $urandom_range(1, 6);
      b2b = (i > 0) && ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        wait_idle();
        tick($urandom_range(0, 5));
      end
      frm.delete();
      for (int j = 0; j < l; j++) frm.push_back(8'($urandom_range(0, 255)));
      send_frame(frm, b2b);
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(2, 60));
        bus.start = 1'b1;
        bus.len = 8'($urandom_range(0, 255));
        tick(1);
        bus.start = 1'b0;
      end
    end

    wait_idle();
    tick(5);
    check("scoreboard_drained", exp_kind.size(), 0);
    check("done_total", done_seen, exp_done_total);
    check("abort_total", abort_seen, exp_abort_total);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
